// File: rtl/hex_seq_pkg.sv
// rtl/hex_seq_pkg.sv - register map, control bits and font for the HEX display sequencer
package hex_seq_pkg;

  localparam logic [2:0] ADDR_DIGIT0 = 3'd0;
  localparam logic [2:0] ADDR_DIGIT1 = 3'd1;
  localparam logic [2:0] ADDR_DIGIT2 = 3'd2;
  localparam logic [2:0] ADDR_DIGIT3 = 3'd3;
  localparam logic [2:0] ADDR_DIGIT4 = 3'd4;
  localparam logic [2:0] ADDR_DIGIT5 = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_RATE   = 3'd7;

  localparam int CTRL_SCROLL_EN  = 0;
  localparam int CTRL_BLINK_EN   = 1;
  localparam int CTRL_SCROLL_DIR = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit order g..a
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - combinational hex nibble to active-low 7-segment lookup
module hex7seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import hex_seq_pkg::*;

  assign seg = FONT[nibble];

endmodule

// File: rtl/hex_display_sequencer.sv
// rtl/hex_display_sequencer.sv - Avalon-MM slave driving six HEX displays with scroll and blink
module hex_display_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int RATE_W     = 16,
  parameter int NUM_DIGITS = 6
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic [5:0]  display_enable,
  output logic [41:0] hex_segments
);
  import hex_seq_pkg::*;

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [3:0]        digit_q [NUM_DIGITS];
  logic [3:0]        digit_d [NUM_DIGITS];
  logic [2:0]        ctrl_q, ctrl_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [2:0]        offset_q, offset_d;
  logic              blink_phase_q, blink_phase_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [41:0]       seg_q, seg_d;

  logic              tick;
  logic              step;
  logic              ctrl_wr;
  logic [RATE_W:0]   cnt_inc;
  logic [6:0]        font_seg [NUM_DIGITS];
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata[31:RATE_W];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex7seg_decoder u_dec (
      .nibble (digit_q[g]),
      .seg    (font_seg[g])
    );
  end

  function automatic logic [2:0] rot_sel(input logic [2:0] off, input int pos);
    int s;
    s = int'(off) + pos;
    if (s >= NUM_DIGITS) s -= NUM_DIGITS;
    return 3'(s);
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);

    // >= compare so a RATE rewritten below the running count fires on the next tick
    cnt_inc = {1'b0, cnt_q} + {{RATE_W{1'b0}}, 1'b1};
    step    = 1'b0;
    cnt_d   = cnt_q;
    if (tick) begin
      if ((rate_q != '0) && (cnt_inc >= {1'b0, rate_q})) begin
        step  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc[RATE_W-1:0];
      end
    end
  end

  always_comb begin
    ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = digit_q[i];
      if (avs_write && (avs_address == ADDR_DIGIT0 + 3'(i))) digit_d[i] = avs_writedata[3:0];
    end
    ctrl_d = ctrl_wr ? avs_writedata[2:0] : ctrl_q;
    rate_d = (avs_write && (avs_address == ADDR_RATE)) ? avs_writedata[RATE_W-1:0] : rate_q;

    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DIGIT0: rdata_d = {28'd0, digit_q[0]};
        ADDR_DIGIT1: rdata_d = {28'd0, digit_q[1]};
        ADDR_DIGIT2: rdata_d = {28'd0, digit_q[2]};
        ADDR_DIGIT3: rdata_d = {28'd0, digit_q[3]};
        ADDR_DIGIT4: rdata_d = {28'd0, digit_q[4]};
        ADDR_DIGIT5: rdata_d = {28'd0, digit_q[5]};
        ADDR_CTRL:   rdata_d = {29'd0, ctrl_q};
        ADDR_RATE:   rdata_d = 32'(rate_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    offset_d      = offset_q;
    blink_phase_d = blink_phase_q;
    if (step && ctrl_q[CTRL_SCROLL_EN]) begin
      if (ctrl_q[CTRL_SCROLL_DIR]) offset_d = (offset_q == 3'd0) ? 3'd5 : offset_q - 3'd1;
      else                         offset_d = (offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1;
    end
    if (step && ctrl_q[CTRL_BLINK_EN]) blink_phase_d = ~blink_phase_q;
    // Clearing an enable bit snaps the state home, overriding a coincident step
    if (ctrl_wr && !avs_writedata[CTRL_SCROLL_EN]) offset_d = 3'd0;
    if (ctrl_wr && !avs_writedata[CTRL_BLINK_EN])  blink_phase_d = 1'b1;
  end

  always_comb begin
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!display_enable[i] || (ctrl_q[CTRL_BLINK_EN] && !blink_phase_q))
        seg_d[7*i +: 7] = SEG_BLANK;
      else
        seg_d[7*i +: 7] = font_seg[rot_sel(offset_q, i)];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      ctrl_q        <= '0;
      rate_q        <= '0;
      presc_q       <= '0;
      cnt_q         <= '0;
      offset_q      <= '0;
      blink_phase_q <= 1'b1;
      rdata_q       <= '0;
      seg_q         <= '1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      ctrl_q        <= ctrl_d;
      rate_q        <= rate_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      offset_q      <= offset_d;
      blink_phase_q <= blink_phase_d;
      rdata_q       <= rdata_d;
      seg_q         <= seg_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign hex_segments = seg_q;

endmodule
